// File: rtl/dma_cmd_reader_if.sv
// AHB-Lite read-master bus bundle for the DMA command reader.
// The master modport is the DMA side, the slave modport is the interconnect side.
interface dma_cmd_reader_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST,
        input  HREADY, HRESP, HRDATA
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST,
        output HREADY, HRESP, HRDATA
    );
endinterface

// File: rtl/dma_cmd_reader.sv
// DMA command reader: fetches one command's words over AHB-Lite INCR reads into a stream FIFO.
// Optional macro DMA_RD_PERF_CNT_EN adds the o_wait_cycles wait-state counter output.
module dma_cmd_reader #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic [15:0]          i_RCC_DMA_ADDR_HIGH,
    input  logic [15:0]          i_RCC_DMA_ADDR_LOW,
    input  logic [5:0]           i_RCC_BUFFER_LENGTH,
    dma_cmd_reader_if.master     ahb,
    output logic [31:0]          o_rd_data,
    output logic                 o_rd_valid,
    input  logic                 i_rd_ready,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error
`ifdef DMA_RD_PERF_CNT_EN
    ,
    output logic [15:0]          o_wait_cycles
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] LP_DEPTH = (CW+1)'(FIFO_DEPTH);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_ERR} state_t;

    state_t         r_state;
    logic [31:0]    r_addr;
    logic [1:0]     r_htrans;
    logic [5:0]     r_rem;
    logic           r_dphase;
    logic           r_cmd_ready;
    logic           r_done;
    logic           r_error;
    logic [31:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;

    state_t         w_state_nxt;
    logic [31:0]    w_addr_nxt;
    logic [1:0]     w_htrans_nxt;
    logic [5:0]     w_rem_nxt;
    logic           w_dphase_nxt;
    logic           w_done_nxt;
    logic           w_error_nxt;
    logic           w_accept;
    logic           w_push;
    logic           w_pop;
    logic [CW-1:0]  w_count_nxt;
    logic [CW:0]    w_slots;
    logic           w_unused_addr_lsb;

    assign w_unused_addr_lsb = ^i_RCC_DMA_ADDR_LOW[1:0];

    assign w_push      = r_dphase & ahb.HREADY & ~ahb.HRESP;
    assign w_pop       = (r_count != '0) & i_rd_ready;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    // Slots are reserved at address issue, so FIFO entries plus in-flight beats never exceed depth.
    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_htrans_nxt = r_htrans;
        w_rem_nxt    = r_rem;
        w_dphase_nxt = r_dphase;
        w_done_nxt   = 1'b0;
        w_error_nxt  = 1'b0;
        w_accept     = 1'b0;
        w_slots      = '0;
        case (r_state)
            S_IDLE: begin
                if (i_cmd_valid && r_cmd_ready) begin
                    w_accept   = 1'b1;
                    w_addr_nxt = {i_RCC_DMA_ADDR_HIGH, i_RCC_DMA_ADDR_LOW[15:2], 2'b00};
                    w_rem_nxt  = i_RCC_BUFFER_LENGTH;
                    if (i_RCC_BUFFER_LENGTH == 6'd0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt  = S_RUN;
                        w_slots      = {1'b0, w_count_nxt};
                        w_htrans_nxt = (w_slots < LP_DEPTH) ? TR_NONSEQ : TR_IDLE;
                    end
                end
            end
            S_RUN: begin
                if (r_dphase && ahb.HRESP) begin
                    w_state_nxt  = S_ERR;
                    w_htrans_nxt = TR_IDLE;
                    w_error_nxt  = 1'b1;
                    w_dphase_nxt = ahb.HREADY ? r_htrans[1] : r_dphase;
                end else if (ahb.HREADY) begin
                    w_dphase_nxt = r_htrans[1];
                    if (r_htrans[1]) begin
                        w_addr_nxt = r_addr + 32'd4;
                        w_rem_nxt  = r_rem - 6'd1;
                    end
                    w_slots = {1'b0, w_count_nxt} + {{CW{1'b0}}, w_dphase_nxt};
                    if (w_rem_nxt == 6'd0) begin
                        w_state_nxt  = S_DRAIN;
                        w_htrans_nxt = TR_IDLE;
                    end else if (w_slots < LP_DEPTH) begin
                        // Restart the burst after a gap and at every 1KB boundary.
                        w_htrans_nxt = ((r_htrans == TR_IDLE) || (w_addr_nxt[9:0] == 10'd0))
                                       ? TR_NONSEQ : TR_SEQ;
                    end else begin
                        w_htrans_nxt = TR_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (r_dphase && ahb.HRESP) begin
                    w_state_nxt  = S_ERR;
                    w_error_nxt  = 1'b1;
                    w_dphase_nxt = ahb.HREADY ? 1'b0 : r_dphase;
                end else if (!r_dphase || ahb.HREADY) begin
                    w_state_nxt  = S_IDLE;
                    w_dphase_nxt = 1'b0;
                    w_done_nxt   = 1'b1;
                end
            end
            S_ERR: begin
                w_htrans_nxt = TR_IDLE;
                if (!r_dphase || ahb.HREADY) begin
                    w_state_nxt  = S_IDLE;
                    w_dphase_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_htrans    <= TR_IDLE;
            r_rem       <= '0;
            r_dphase    <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_htrans    <= w_htrans_nxt;
            r_rem       <= w_rem_nxt;
            r_dphase    <= w_dphase_nxt;
            r_cmd_ready <= (w_state_nxt == S_IDLE);
            r_done      <= w_done_nxt;
            r_error     <= w_error_nxt;
            r_count     <= w_count_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge HCLK) begin
        if (w_push) r_mem[r_wr_ptr] <= ahb.HRDATA;
    end

`ifdef DMA_RD_PERF_CNT_EN
    logic [15:0] r_wait_cycles;

    always_ff @(posedge HCLK) begin
        if (HRESET || w_accept) begin
            r_wait_cycles <= '0;
        end else if (((r_state == S_RUN) || (r_state == S_DRAIN)) &&
                     ((r_htrans != TR_IDLE) || r_dphase) && !ahb.HREADY &&
                     (r_wait_cycles != 16'hFFFF)) begin
            r_wait_cycles <= r_wait_cycles + 16'd1;
        end
    end

    assign o_wait_cycles = r_wait_cycles;
`endif

    assign ahb.HADDR  = r_addr;
    assign ahb.HTRANS = r_htrans;
    assign ahb.HWRITE = 1'b0;
    assign ahb.HSIZE  = 3'b010;
    assign ahb.HBURST = 3'b001;

    assign o_cmd_ready = r_cmd_ready;
    assign o_rd_valid  = (r_count != '0);
    assign o_rd_data   = o_rd_valid ? r_mem[r_rd_ptr] : '0;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = r_done;
    assign o_error     = r_error;

endmodule

// File: tb/tb_dma_cmd_reader.sv
// Scoreboard bench for dma_cmd_reader: a behavioural AHB slave feeds read data, and
// negedge monitors check completed address phases and popped stream words against queues.
`timescale 1ns/1ps
module tb_dma_cmd_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] addr_hi;
    logic [15:0] addr_lo;
    logic [5:0]  len;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        busy;
    logic        done;
    logic        error;
`ifdef DMA_RD_PERF_CNT_EN
    logic [15:0] wait_cycles;
`endif

    dma_cmd_reader_if bus();

    dma_cmd_reader #(.FIFO_DEPTH(4)) dut (
        .HCLK                (clk),
        .HRESET              (rst),
        .i_cmd_valid         (cmd_valid),
        .o_cmd_ready         (cmd_ready),
        .i_RCC_DMA_ADDR_HIGH (addr_hi),
        .i_RCC_DMA_ADDR_LOW  (addr_lo),
        .i_RCC_BUFFER_LENGTH (len),
        .ahb                 (bus),
        .o_rd_data           (rd_data),
        .o_rd_valid          (rd_valid),
        .i_rd_ready          (rd_ready),
        .o_busy              (busy),
        .o_done              (done),
        .o_error             (error)
`ifdef DMA_RD_PERF_CNT_EN
        ,
        .o_wait_cycles       (wait_cycles)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [33:0] exp_beat [$];
    logic [31:0] exp_data [$];
    int n_addr = 0;
    int n_done = 0;
    int n_err  = 0;
    int n_busy_trans = 0;

    int beat_no    = 0;
    int err_beat   = 0;
    int stall_beat = 0;
    int stall_len  = 0;

    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] SQ = 2'b11;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hC0DE_5A5A;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push_beat(input logic [31:0] a, input logic [1:0] tr, input bit with_data);
        exp_beat.push_back({tr, a});
        if (with_data) exp_data.push_back(data_of(a));
    endtask

    // Caller is positioned #1 after a posedge; returns #1 after the accepting edge.
    task automatic send_cmd(input logic [31:0] a, input logic [5:0] l);
        int n;
        beat_no   = 0;
        addr_hi   = a[31:16];
        addr_lo   = a[15:0];
        len       = l;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("cmd_accept_timeout", n >= 100, 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || rd_valid) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, n >= 400, 0);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic chk_queues(input string name);
        chk(name, {exp_beat.size(), exp_data.size()}, 0);
    endtask

    // Output monitor: compares completed address phases and popped words.
    initial begin
        logic [33:0] eb;
        logic [31:0] ed;
        forever begin
            @(negedge clk);
            if (rd_valid && rd_ready) begin
                if (exp_data.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_word: got %0h required none", rd_data);
                end else begin
                    ed = exp_data.pop_front();
                    chk("rd_data", rd_data, ed);
                end
            end
            if (bus.HTRANS != 2'b00 && bus.HREADY) begin
                n_addr++;
                if (exp_beat.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_beat: got %0h required none", {bus.HTRANS, bus.HADDR});
                end else begin
                    eb = exp_beat.pop_front();
                    chk("haddr_htrans", {bus.HTRANS, bus.HADDR}, eb);
                end
            end
            if (bus.HRESP && bus.HREADY) chk("htrans_2nd_err_cycle", bus.HTRANS, 2'b00);
            if (bus.HTRANS != 2'b00) n_busy_trans++;
            if (done)  n_done++;
            if (error) n_err++;
        end
    end

    // AHB slave: one data phase per completed address phase, optional error and wait states.
    initial begin
        logic        dp;
        logic        new_dp;
        logic [31:0] dpa;
        logic [1:0]  st;
        logic [31:0] sa;
        int          stall_left;
        int          es;
        dp = 1'b0; dpa = '0; stall_left = 0; es = 0; new_dp = 1'b0;
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        bus.HRDATA = '0;
        forever begin
            @(negedge clk);
            st = bus.HTRANS;
            sa = bus.HADDR;
            @(posedge clk);
            new_dp = 1'b0;
            if (rst) begin
                dp = 1'b0; stall_left = 0; es = 0;
            end else if (bus.HREADY) begin
                dp  = (st === NS) || (st === SQ);
                dpa = sa;
                es  = 0;
                if (dp) begin
                    beat_no++;
                    new_dp = 1'b1;
                    if (beat_no == stall_beat) stall_left = stall_len;
                end
            end
            #1;
            bus.HRESP  = 1'b0;
            bus.HREADY = 1'b1;
            if (dp) begin
                bus.HRDATA = data_of(dpa);
                if (es == 1) begin
                    es = 2;
                    bus.HRESP = 1'b1;
                end else if (new_dp && beat_no == err_beat) begin
                    es = 1;
                    bus.HRESP  = 1'b1;
                    bus.HREADY = 1'b0;
                end else if (stall_left > 0) begin
                    stall_left--;
                    bus.HREADY = 1'b0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        int d0, e0, a0, t0, n;
        rst = 1'b1; cmd_valid = 1'b0; addr_hi = '0; addr_lo = '0; len = '0; rd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_htrans",    bus.HTRANS, 2'b00);
        chk("rst_haddr",     bus.HADDR, 32'h0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rd_valid",  rd_valid, 0);
        chk("rst_rd_data",   rd_data, 32'h0);
        chk("rst_flags",     {busy, done, error}, 3'b000);
        chk("const_ctrl",    {bus.HWRITE, bus.HSIZE, bus.HBURST}, 7'b0_010_001);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: plain 4-beat burst
        d0 = n_done;
        push_beat(32'h2000_0010, NS, 1);
        push_beat(32'h2000_0014, SQ, 1);
        push_beat(32'h2000_0018, SQ, 1);
        push_beat(32'h2000_001C, SQ, 1);
        send_cmd(32'h2000_0010, 6'd4);
        wait_idle("t1_idle_timeout");
        chk_queues("t1_queues");
        chk("t1_done_count", n_done - d0, 1);

        // 2: zero-length command
        d0 = n_done; t0 = n_busy_trans;
        send_cmd(32'h3000_0000, 6'd0);
        chk("t2_done_pulse", done, 1);
        chk("t2_cmd_ready",  cmd_ready, 1);
        @(posedge clk); #1;
        chk("t2_done_low",   {done, busy, cmd_ready}, 3'b001);
        repeat (4) begin @(posedge clk); #1; end
        chk("t2_no_trans",   n_busy_trans - t0, 0);
        chk("t2_done_count", n_done - d0, 1);

        // 3: 1KB boundary forces NONSEQ
        push_beat(32'h0000_03F8, NS, 1);
        push_beat(32'h0000_03FC, SQ, 1);
        push_beat(32'h0000_0400, NS, 1);
        push_beat(32'h0000_0404, SQ, 1);
        send_cmd(32'h0000_03F8, 6'd4);
        wait_idle("t3_idle_timeout");
        chk_queues("t3_queues");

        // 4: back-pressure limits fetch to FIFO depth
        d0 = n_done; a0 = n_addr;
        rd_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            push_beat(32'h1000_0100 + 32'(4*i), (i == 0 || i == 4) ? NS : SQ, 1);
        send_cmd(32'h1000_0100, 6'd8);
        repeat (12) begin @(posedge clk); #1; end
        chk("t4_first_fetch", n_addr - a0, 4);
        t0 = n_busy_trans;
        repeat (6) begin @(posedge clk); #1; end
        chk("t4_idle_while_full", n_busy_trans - t0, 0);
        chk("t4_rd_valid", rd_valid, 1);
        rd_ready = 1'b1;
        wait_idle("t4_idle_timeout");
        chk("t4_total_fetch", n_addr - a0, 8);
        chk_queues("t4_queues");
        chk("t4_done_count", n_done - d0, 1);

        // 5: error response on beat 3
        d0 = n_done; e0 = n_err; a0 = n_addr;
        rd_ready = 1'b0;
        err_beat = 3;
        push_beat(32'h2000_0040, NS, 1);
        push_beat(32'h2000_0044, SQ, 1);
        push_beat(32'h2000_0048, SQ, 0);
        send_cmd(32'h2000_0040, 6'd6);
        n = 0;
        while (busy && n < 100) begin @(posedge clk); #1; n++; end
        chk("t5_busy_timeout", n >= 100, 0);
        repeat (4) begin @(posedge clk); #1; end
        chk("t5_error_count", n_err - e0, 1);
        chk("t5_beats", n_addr - a0, 3);
        chk("t5_rd_valid", rd_valid, 1);
        rd_ready = 1'b1;
        wait_idle("t5_idle_timeout");
        err_beat = 0;
        chk_queues("t5_queues");
        chk("t5_no_done", n_done - d0, 0);

        // 6: reset during a stalled data phase
        stall_beat = 2; stall_len = 1000;
        push_beat(32'h4000_0000, NS, 1);
        push_beat(32'h4000_0004, SQ, 0);
        send_cmd(32'h4000_0000, 6'd10);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.HREADY == 1'b0 && busy) && n < 50);
        chk("t6_stall_timeout", n >= 50, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_after_rst", {bus.HTRANS, rd_valid, busy}, 4'b0000);
        rst = 1'b0;
        stall_beat = 0;
        @(posedge clk); #1;
        chk_queues("t6_queues_at_rst");
        d0 = n_done;
        push_beat(32'h5000_0020, NS, 1);
        push_beat(32'h5000_0024, SQ, 1);
        send_cmd(32'h5000_0020, 6'd2);
        wait_idle("t6_idle_timeout");
        chk_queues("t6_queues");
        chk("t6_done_count", n_done - d0, 1);

        // 7: wait states hold SEQ address
        stall_beat = 2; stall_len = 2;
        push_beat(32'h6000_0080, NS, 1);
        push_beat(32'h6000_0084, SQ, 1);
        push_beat(32'h6000_0088, SQ, 1);
        send_cmd(32'h6000_0080, 6'd3);
        wait_idle("t7_idle_timeout");
        stall_beat = 0;
        chk_queues("t7_queues");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
